// File: rtl/cnt_dn_timer.sv
// Programmable modulo-M down-counting timer with one-shot and auto-reload modes.
// Loads a saturated start value, counts to zero, and pulses done on each expiry.
module cnt_dn_timer #(
  parameter int unsigned width = 4,
  parameter int unsigned model = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [width-1:0] load_val,
  input  logic             auto_reload,
  output logic [width-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [width-1:0] CNT_MAX = width'(model - 1);

  state_t           state_q, state_d;
  logic [width-1:0] cnt_q, cnt_d;
  logic [width-1:0] reload_q, reload_d;
  logic [width-1:0] load_sat;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    load_sat = (load_val > CNT_MAX) ? CNT_MAX : load_val;
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !stop) begin
          cnt_d    = load_sat;
          reload_d = load_sat;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Abort outranks expiry, so a stop on the zero cycle suppresses done.
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - width'(1);
        end else begin
          done_d = 1'b1;
          if (auto_reload) cnt_d = reload_q;
          else             state_d = IDLE;
        end
      end
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign tc   = busy_q && (cnt_q == '0);

endmodule

// File: tb/tb_cnt_dn_timer.sv
// Scoreboard bench for cnt_dn_timer: expected per-cycle {cnt,busy,done,tc}
// words are queued from the timing rules and compared after each clock edge.
module tb_cnt_dn_timer;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] load_val = '0;
  logic       auto_reload = 1'b0;
  logic [3:0] cnt;
  logic       busy, done, tc;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [6:0]  sb[$];
  logic [6:0]  got, want;

  cnt_dn_timer #(.width(4), .model(10)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .stop       (stop),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .cnt        (cnt),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [6:0] ex(input logic [3:0] c, input logic b, input logic d);
    return {c, b, d, b && (c == 4'd0)};
  endfunction

  // One run of length L after its start edge: L..0 busy, then the done cycle.
  function automatic void push_oneshot(input int unsigned l, input bit tail);
    for (int unsigned k = 0; k <= l; k++) sb.push_back(ex(4'(l - k), 1'b1, 1'b0));
    sb.push_back(ex(4'd0, 1'b0, 1'b1));
    if (tail) sb.push_back(ex(4'd0, 1'b0, 1'b0));
  endfunction

  task automatic test_reset();
    @(posedge sys_clk); #1;
    got = {cnt, busy, done, tc};
    checks++;
    if (got !== 7'd0) begin
      errors++;
      $display("FAIL reset: got %b expected %b", got, 7'd0);
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_one_shot();
    load_val = 4'd5; auto_reload = 1'b0; start = 1'b1;
    push_oneshot(5, 1'b1);
    sb.push_back(ex(4'd0, 1'b0, 1'b0));
    for (int i = 0; i < 9; i++) begin
      @(posedge sys_clk); #1;
      got = {cnt, busy, done, tc}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL one_shot cyc %0d: got cnt=%0d busy=%b done=%b tc=%b expected cnt=%0d busy=%b done=%b tc=%b",
                 i, got[6:3], got[2], got[1], got[0], want[6:3], want[2], want[1], want[0]);
      end
      if (i == 0) start = 1'b0;
    end
  endtask

  task automatic test_auto_reload();
    load_val = 4'd3; auto_reload = 1'b1; start = 1'b1;
    for (int unsigned k = 0; k < 20; k++)
      sb.push_back(ex(4'(3 - (k % 4)), 1'b1, (k > 0) && (k % 4 == 0)));
    sb.push_back(ex(4'd0, 1'b0, 1'b1));
    sb.push_back(ex(4'd0, 1'b0, 1'b0));
    for (int i = 0; i < 22; i++) begin
      @(posedge sys_clk); #1;
      got = {cnt, busy, done, tc}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL auto_reload cyc %0d: got cnt=%0d busy=%b done=%b tc=%b expected cnt=%0d busy=%b done=%b tc=%b",
                 i, got[6:3], got[2], got[1], got[0], want[6:3], want[2], want[1], want[0]);
      end
      if (i == 0) start = 1'b0;
      if (i == 19) auto_reload = 1'b0;
    end
  endtask

  task automatic test_saturation_zero();
    load_val = 4'd15; start = 1'b1;
    push_oneshot(9, 1'b1);
    push_oneshot(0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(posedge sys_clk); #1;
      got = {cnt, busy, done, tc}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sat_zero cyc %0d: got cnt=%0d busy=%b done=%b tc=%b expected cnt=%0d busy=%b done=%b tc=%b",
                 i, got[6:3], got[2], got[1], got[0], want[6:3], want[2], want[1], want[0]);
      end
      if (i == 0) start = 1'b0;
      if (i == 11) begin load_val = 4'd0; start = 1'b1; end
      if (i == 12) start = 1'b0;
    end
  endtask

  task automatic test_stop_start_priority();
    load_val = 4'd5; start = 1'b1;
    for (int unsigned k = 0; k < 4; k++) sb.push_back(ex(4'(5 - k), 1'b1, 1'b0));
    repeat (3) sb.push_back(ex(4'd0, 1'b0, 1'b0));
    repeat (2) sb.push_back(ex(4'd0, 1'b0, 1'b0));
    push_oneshot(4, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(posedge sys_clk); #1;
      got = {cnt, busy, done, tc}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stop_start cyc %0d: got cnt=%0d busy=%b done=%b tc=%b expected cnt=%0d busy=%b done=%b tc=%b",
                 i, got[6:3], got[2], got[1], got[0], want[6:3], want[2], want[1], want[0]);
      end
      case (i)
        0:  start = 1'b0;
        3:  stop = 1'b1;
        4:  stop = 1'b0;
        6:  begin start = 1'b1; stop = 1'b1; end
        7:  begin start = 1'b0; stop = 1'b0; end
        8:  begin start = 1'b1; load_val = 4'd4; end
        9:  load_val = 4'd9;
        11: start = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_async_reset();
    load_val = 4'd6; start = 1'b1;
    for (int unsigned k = 0; k < 3; k++) sb.push_back(ex(4'(6 - k), 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk); #1;
      got = {cnt, busy, done, tc}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL async_pre cyc %0d: got %b expected %b", i, got, want);
      end
      if (i == 0) start = 1'b0;
    end
    #2 sys_rst_n = 1'b0;
    #1;
    got = {cnt, busy, done, tc}; checks++;
    if (got !== 7'd0) begin
      errors++;
      $display("FAIL async_immediate: got %b expected %b", got, 7'd0);
    end
    @(posedge sys_clk); #1;
    got = {cnt, busy, done, tc}; checks++;
    if (got !== 7'd0) begin
      errors++;
      $display("FAIL async_held: got %b expected %b", got, 7'd0);
    end
    sys_rst_n = 1'b1;
    load_val = 4'd2; start = 1'b1;
    push_oneshot(2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk); #1;
      got = {cnt, busy, done, tc}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL async_restart cyc %0d: got cnt=%0d busy=%b done=%b tc=%b expected cnt=%0d busy=%b done=%b tc=%b",
                 i, got[6:3], got[2], got[1], got[0], want[6:3], want[2], want[1], want[0]);
      end
      if (i == 0) start = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    load_val = 4'd1; start = 1'b1;
    push_oneshot(1, 1'b0);
    push_oneshot(1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(posedge sys_clk); #1;
      got = {cnt, busy, done, tc}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got cnt=%0d busy=%b done=%b tc=%b expected cnt=%0d busy=%b done=%b tc=%b",
                 i, got[6:3], got[2], got[1], got[0], want[6:3], want[2], want[1], want[0]);
      end
      if (i == 0) start = 1'b0;
      if (i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_saturation_zero();
    test_stop_start_priority();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
